// File: rtl/stopwatch_cu.sv
// stopwatch_cu: run/stop/clear control unit for the stopwatch datapath.
// It merges debounced button pulses and UART command bytes into a single FSM.
// It drives the datapath run-enable and clear, and echoes each accepted UART
// command to the UART transmitter.
// Optional feature macro: STOPWATCH_UART_CMD_EN. When it is undefined, the
// UART inputs are ignored and the echo outputs are tied to zero.
module stopwatch_cu #(
    parameter logic [7:0] CMD_RUNSTOP = 8'h72,
    parameter logic [7:0] CMD_CLEAR   = 8'h63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_runstop,
    input  logic       i_btn_clear,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_done,
    input  logic       i_tx_busy,
    output logic       o_runstop,
    output logic       o_clear,
    output logic [1:0] o_state,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   btn_any;
    logic   uart_rs;
    logic   uart_cl;
    logic   ev_rs;
    logic   ev_cl;
    logic   accept;

    // A button pulse in a cycle masks any UART command arriving in that cycle.
    assign btn_any = i_btn_runstop | i_btn_clear;

`ifdef STOPWATCH_UART_CMD_EN
    assign uart_rs = i_rx_done && !btn_any && (i_rx_data == CMD_RUNSTOP);
    assign uart_cl = i_rx_done && !btn_any && (i_rx_data == CMD_CLEAR);
`else
    assign uart_rs = 1'b0;
    assign uart_cl = 1'b0;
`endif

    assign ev_rs = i_btn_runstop | uart_rs;
    assign ev_cl = i_btn_clear | uart_cl;

    // State register; the illegal encoding is steered back to STOP by the next-state logic.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments only,
        // so every register samples the values from before this edge.
        if (rst) begin
            state <= ST_STOP;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; accept marks a UART command that causes a transition.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch behind.
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_STOP: begin
                if (ev_rs) begin
                    state_next = ST_RUN;
                    accept     = uart_rs;
                end else if (ev_cl) begin
                    state_next = ST_CLEAR;
                    accept     = uart_cl;
                end
            end
            ST_RUN: begin
                if (ev_rs) begin
                    state_next = ST_STOP;
                    accept     = uart_rs;
                end
            end
            ST_CLEAR: state_next = ST_STOP;
            default:  state_next = ST_STOP;
        endcase
    end

    assign o_runstop = (state == ST_RUN);
    assign o_clear   = (state == ST_CLEAR);
    assign o_state   = state;

`ifdef STOPWATCH_UART_CMD_EN
    logic       pending;
    logic [7:0] pend_data;
    logic [7:0] last_data;
    logic       start_q;
    logic       tx_start;

    // start_q blocks a start in the cycle right after a start. This keeps
    // the strobe to one cycle even when a new command refills pending at once.
    assign tx_start = pending && !i_tx_busy && !start_q;

    // One-entry echo buffer (latest accepted command wins) plus the last sent byte.
    always_ff @(posedge clk) begin
        // NOTE: the data registers are reset too, so o_tx_data reads 8'h00
        // after reset and a pending echo cannot leak across the reset.
        if (rst) begin
            pending   <= 1'b0;
            pend_data <= 8'h00;
            last_data <= 8'h00;
            start_q   <= 1'b0;
        end else begin
            start_q <= tx_start;
            if (tx_start) begin
                last_data <= pend_data;
            end
            if (accept) begin
                pending   <= 1'b1;
                pend_data <= i_rx_data;
            end else if (tx_start) begin
                pending <= 1'b0;
            end
        end
    end

    assign o_tx_start = tx_start;
    assign o_tx_data  = tx_start ? pend_data : last_data;
`else
    logic unused_uart;
    assign unused_uart = ^{i_rx_data, i_rx_done, i_tx_busy, accept, ev_cl,
                           CMD_RUNSTOP, CMD_CLEAR};
    assign o_tx_start  = 1'b0;
    assign o_tx_data   = 8'h00;
`endif

endmodule

// File: tb/tb_stopwatch_cu.sv
// Testbench for stopwatch_cu. Directed steps from the test plan run first,
// then a randomized phase. Every cycle is compared against a
// behavioural model that holds the state and a queue for the pending echo.
module tb_stopwatch_cu;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_btn_runstop;
    logic       i_btn_clear;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic       i_tx_busy;
    logic       o_runstop;
    logic       o_clear;
    logic [1:0] o_state;
    logic [7:0] o_tx_data;
    logic       o_tx_start;

    always #5 clk = ~clk;

    stopwatch_cu dut (
        .clk          (clk),
        .rst          (rst),
        .i_btn_runstop(i_btn_runstop),
        .i_btn_clear  (i_btn_clear),
        .i_rx_data    (i_rx_data),
        .i_rx_done    (i_rx_done),
        .i_tx_busy    (i_tx_busy),
        .o_runstop    (o_runstop),
        .o_clear      (o_clear),
        .o_state      (o_state),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start)
    );

`ifdef STOPWATCH_UART_CMD_EN
    localparam bit UART_EN = 1'b1;
`else
    localparam bit UART_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int starts_seen = 0;

    // Reference model: 0 = STOP, 1 = RUN, 2 = CLEAR; echo backlog as a queue.
    int         m_state;
    logic [7:0] m_pend[$];
    bit         m_last_start;
    logic [7:0] m_last_data;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare outputs, take the edge, then advance the model.
    task automatic tick(input bit r, input bit brs, input bit bcl,
                        input bit rd, input logic [7:0] rdata, input bit busy);
        bit         exp_start;
        logic [7:0] exp_data;
        bit         u_rs;
        bit         u_cl;
        bit         rs;
        bit         cl;
        rst           = r;
        i_btn_runstop = brs;
        i_btn_clear   = bcl;
        i_rx_done     = rd;
        i_rx_data     = rdata;
        i_tx_busy     = busy;
        #1;
        exp_start = UART_EN && (m_pend.size() != 0) && !busy && !m_last_start;
        exp_data  = exp_start ? m_pend[0] : m_last_data;
        check("runstop",  8'(o_runstop),  8'(m_state == 1));
        check("clear",    8'(o_clear),    8'(m_state == 2));
        check("state",    8'(o_state),    8'(m_state));
        check("tx_start", 8'(o_tx_start), 8'(exp_start));
        check("tx_data",  o_tx_data,      exp_data);
        if (o_tx_start === 1'b1) starts_seen++;
        @(posedge clk);
        #1;
        if (r) begin
            m_state      = 0;
            m_pend.delete();
            m_last_start = 1'b0;
            m_last_data  = 8'h00;
        end else begin
            if (exp_start) begin
                m_last_data = m_pend[0];
                m_pend.delete();
            end
            m_last_start = exp_start;
            u_rs = UART_EN && rd && !brs && !bcl && (rdata == 8'h72);
            u_cl = UART_EN && rd && !brs && !bcl && (rdata == 8'h63);
            rs   = brs || u_rs;
            cl   = bcl || u_cl;
            if (m_state == 2) begin
                m_state = 0;
            end else if (m_state == 0) begin
                if (rs) begin
                    m_state = 1;
                    if (u_rs) begin m_pend.delete(); m_pend.push_back(rdata); end
                end else if (cl) begin
                    m_state = 2;
                    if (u_cl) begin m_pend.delete(); m_pend.push_back(rdata); end
                end
            end else if (rs) begin
                m_state = 0;
                if (u_rs) begin m_pend.delete(); m_pend.push_back(rdata); end
            end
        end
    endtask

    task automatic idle(input int n, input bit busy);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, busy);
    endtask

    initial begin
        int         base;
        logic [7:0] b;
        int         sel;

        rst = 1'b1; i_btn_runstop = 1'b0; i_btn_clear = 1'b0;
        i_rx_done = 1'b0; i_rx_data = 8'h00; i_tx_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst          = 1'b0;
        m_state      = 0;
        m_pend.delete();
        m_last_start = 1'b0;
        m_last_data  = 8'h00;

        // Reset state, then run/stop toggling by button.
        idle(1, 1'b0);
        tick(0, 1, 0, 0, 8'h00, 0);
        check("plan_run_state", 8'(o_state), 8'd1);
        tick(0, 1, 0, 0, 8'h00, 0);
        check("plan_stop_state", 8'(o_state), 8'd0);

        // Clear from STOP lasts one cycle; clear in RUN is ignored.
        tick(0, 0, 1, 0, 8'h00, 0);
        check("plan_clear_hi", 8'(o_clear), 8'd1);
        idle(1, 1'b0);
        check("plan_clear_lo", 8'(o_clear), 8'd0);
        tick(0, 1, 0, 0, 8'h00, 0);
        tick(0, 0, 1, 0, 8'h00, 0);
        check("plan_run_ignores_clear", 8'(o_state), 8'd1);
        tick(0, 1, 0, 0, 8'h00, 0);

        // UART 'r' with TX idle, a non-command byte, then 'r' back to STOP.
        tick(0, 0, 0, 1, 8'h72, 0);
        check("plan_uart_run", 8'(o_state), 8'(UART_EN));
        idle(2, 1'b0);
        tick(0, 0, 0, 1, 8'h41, 0);
        idle(1, 1'b0);
        tick(0, 0, 0, 1, 8'h72, 0);
        idle(3, 1'b0);

        // Two commands while TX busy collapse into a single echo.
        tick(0, 0, 0, 1, 8'h72, 1);
        idle(2, 1'b1);
        tick(0, 0, 0, 1, 8'h72, 1);
        idle(3, 1'b1);
        base = starts_seen;
        idle(6, 1'b0);
        check("plan_busy_one_start", 8'(starts_seen - base), 8'(UART_EN));

        // Same-cycle priority cases in STOP.
        tick(0, 1, 0, 1, 8'h63, 0);
        check("plan_btn_masks_uart", 8'(o_state), 8'd1);
        idle(2, 1'b0);
        tick(0, 1, 0, 0, 8'h00, 0);
        tick(0, 1, 1, 0, 8'h00, 0);
        check("plan_rs_over_cl", 8'(o_state), 8'd1);
        tick(0, 1, 0, 0, 8'h00, 0);

        // Reset in RUN with an echo pending discards the echo.
        tick(0, 0, 0, 1, 8'h72, 1);
        idle(1, 1'b1);
        tick(1, 0, 0, 0, 8'h00, 1);
        check("plan_rst_runstop", 8'(o_runstop), 8'd0);
        base = starts_seen;
        idle(5, 1'b0);
        check("plan_rst_no_echo", 8'(starts_seen - base), 8'd0);

        // Randomized phase.
        for (int i = 0; i < 800; i++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       b = 8'h72;
                1:       b = 8'h63;
                2:       b = 8'h41;
                default: b = 8'($urandom);
            endcase
            tick(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) == 0),
                 b,
                 ($urandom_range(0, 2) == 0));
        end
        idle(4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
